pi_cmd_receiver: RTL

- Serial command receiver for the RPi link: the RPi-to-FPGA direction of the clocked serial interface whose FPGA-to-RPi side shifts out error and RO counts.
- Pi drives a bit clock, a data line and a save strobe. The block synchronises them into the system clock, deserialises a 16-bit frame MSB-first and checks sync and parity.
- On a valid save it commits clock-generator and data-generator control fields. These replace the hard-wired CLK_CTL and NS_DAT_CTL constants at the test top.

---
 rtl/pi_cmd_receiver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pi_cmd_receiver.sv
// Deserialises 16-bit MSB-first Pi command frames and, on a valid save, commits the clock and data generator controls.
// Latency: cmd_save_pi rise to cfg update takes SYNC_STAGES+2 CLK cycles. There is no backpressure: the Pi paces frames and a stalled frame is aborted after TIMEOUT_CYC.
// Define PI_CMD_READBACK_EN to echo the last accepted frame on cmd_echo_pi while the next frame is shifted in.
module pi_cmd_receiver #(
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [1:0]  CLK_CTL_RST = 2'b10,
    parameter logic [1:0]  DAT_CTL_RST = 2'b01
) (
    input  logic       CLK,
    input  logic       RST_B,
    input  logic       cmd_clk_pi,
    input  logic       cmd_data_pi,
    input  logic       cmd_save_pi,
    output logic       cmd_echo_pi,
    output logic [1:0] cfg_clk_ctl,
    output logic [1:0] cfg_dat_ctl,
    output logic       cfg_rst_req,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [4:0] bit_cnt
);

    localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     SYNC_WORD = 4'b1010;
    localparam logic [4:0]     BITS_FULL = 5'd16;
    localparam logic [4:0]     BITS_OVF  = 5'd17;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [SYNC_STAGES-1:0] save_sync;
    logic                   clk_prev;
    logic                   save_prev;
    logic [15:0]            shreg;
    logic [TW-1:0]          idle_cnt;

    logic clk_s, dat_s, save_s;
    logic clk_rise, clk_edge, save_rise;
    logic frame_good;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            clk_sync  <= '0;
            dat_sync  <= '0;
            save_sync <= '0;
            clk_prev  <= 1'b0;
            save_prev <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], cmd_clk_pi};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], cmd_data_pi};
            save_sync <= {save_sync[SYNC_STAGES-2:0], cmd_save_pi};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            save_prev <= save_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign save_s    = save_sync[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_prev;
    assign clk_edge  = clk_s ^ clk_prev;
    assign save_rise = save_s & ~save_prev;

    assign frame_good = (bit_cnt == BITS_FULL) && (shreg[15:12] == SYNC_WORD) && !(^shreg);

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state       <= IDLE;
            shreg       <= '0;
            idle_cnt    <= '0;
            bit_cnt     <= '0;
            cfg_clk_ctl <= CLK_CTL_RST;
            cfg_dat_ctl <= DAT_CTL_RST;
            cfg_rst_req <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_ok    <= 1'b0;
            cfg_rst_req <= 1'b0;
            case (state)
                IDLE: begin
                    // A save with nothing shifted in still goes through CHECK and is rejected there.
                    if (save_rise) begin
                        state <= CHECK;
                    end else if (clk_rise) begin
                        shreg    <= {shreg[14:0], dat_s};
                        bit_cnt  <= 5'd1;
                        idle_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (save_rise) begin
                        state <= CHECK;
                    end else if (clk_rise) begin
                        shreg    <= {shreg[14:0], dat_s};
                        idle_cnt <= '0;
                        if (bit_cnt != BITS_OVF)
                            bit_cnt <= bit_cnt + 5'd1;
                    end else if (clk_edge) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (frame_good) begin
                        cfg_clk_ctl <= shreg[11:10];
                        cfg_dat_ctl <= shreg[9:8];
                        cfg_rst_req <= shreg[7];
                        frame_ok    <= 1'b1;
                        frame_err   <= 1'b0;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PI_CMD_READBACK_EN
    logic [15:0] echo_q;
    logic        take_bit;

    // Mirrors the shift condition above so the echo advances exactly once per accepted data bit.
    assign take_bit = clk_rise && !save_rise && (state != CHECK);

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B)
            echo_q <= '0;
        else if (state == CHECK && frame_good)
            echo_q <= shreg;
        else if (take_bit)
            echo_q <= {echo_q[14:0], 1'b0};
    end

    assign cmd_echo_pi = echo_q[15];
`else
    assign cmd_echo_pi = 1'b0;
`endif

endmodule
